// File: rtl/decoder_nx2n_seq_if.sv
// decoder_nx2n_seq_if: decode/sweep request and result bundle for decoder_nx2n_seq.
//   master: drives EN, IN, SWEEP_START; observes OUT, BUSY, DONE
//   slave : the decoder itself
// Signals:
//   EN          decode enable
//   IN          N-bit select index
//   SWEEP_START request a one-pass sweep over the outputs
//   OUT         registered one-hot (or all-zero) output, 2^N wide
//   BUSY        high while a sweep is driving OUT
//   DONE        one-cycle sweep-completion pulse
interface decoder_nx2n_seq_if #(
  parameter int N = 2
);
  localparam int OUT_W = 1 << N;

  logic             EN;
  logic [N-1:0]     IN;
  logic             SWEEP_START;
  logic [OUT_W-1:0] OUT;
  logic             BUSY;
  logic             DONE;

  modport master (
    output EN, IN, SWEEP_START,
    input  OUT, BUSY, DONE
  );

  modport slave (
    input  EN, IN, SWEEP_START,
    output OUT, BUSY, DONE
  );
endinterface

// File: rtl/decoder_nx2n_seq.sv
// decoder_nx2n_seq: registered N-to-2^N one-hot decoder with a one-pass sweep
// mode that asserts each output index 0..SWEEP_LAST in turn (used to clear the
// register file after reset).
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset (OUT/BUSY/DONE cleared immediately)
//   bus  decoder_nx2n_seq_if.slave: EN, IN, SWEEP_START in; OUT, BUSY, DONE out
// Parameters:
//   N          select width, OUT is 2^N wide
//   SWEEP_LAST highest index driven during a sweep (0..2^N-1)
// Build option:
//   DECODER_HOLD_EN  when defined, IDLE with EN=0 holds OUT instead of clearing
module decoder_nx2n_seq #(
  parameter int N          = 2,
  parameter int SWEEP_LAST = (1 << N) - 1
) (
  input logic               CLK,
  input logic               RST,
  decoder_nx2n_seq_if.slave bus
);
  localparam int           OUT_W    = 1 << N;
  localparam logic [N-1:0] LAST_IDX = N'(SWEEP_LAST);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     shown_idx;
  logic             last_shown;

  function automatic logic [OUT_W-1:0] onehot(input logic [N-1:0] idx);
    logic [OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // CNT runs one ahead of the index currently on OUT, so the sweep ends once
  // the index already displayed is SWEEP_LAST; the FIN entry edge then loads
  // OUT=0 with DONE=1. With SWEEP_LAST=2^N-1 CNT wraps to 0 here, which
  // still yields the right displayed index.
  assign shown_idx  = cnt_q - N'(1);
  assign last_shown = (shown_idx == LAST_IDX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.SWEEP_START) state_d = SWEEP;
      SWEEP:   if (last_shown) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.SWEEP_START) begin
          out_d  = onehot('0);
          cnt_d  = N'(1);
          busy_d = 1'b1;
        end else if (bus.EN) begin
          out_d = onehot(bus.IN);
        end else begin
`ifdef DECODER_HOLD_EN
          out_d = out_q;
`else
          out_d = '0;
`endif
        end
      end
      SWEEP: begin
        if (last_shown) begin
          done_d = 1'b1;
        end else begin
          out_d  = onehot(cnt_q);
          cnt_d  = cnt_q + N'(1);
          busy_d = 1'b1;
        end
      end
      FIN: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign bus.OUT  = out_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// tb_decoder_nx2n_seq: drives two decoders (N=2 full sweep, N=3 with
// SWEEP_LAST=5) with directed and $urandom stimulus and compares every cycle
// against a cycle-count reference model of the decode/sweep timing.
module tb_decoder_nx2n_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_nx2n_seq_if #(.N(2)) bus0 ();
  decoder_nx2n_seq_if #(.N(3)) bus1 ();

  decoder_nx2n_seq #(.N(2)) dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (bus0)
  );

  decoder_nx2n_seq #(.N(3), .SWEEP_LAST(5)) dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (bus1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pos = -1 when idle, otherwise the number of edges since
  // the sweep request (0..sl shows onehot(pos), sl+1 is the DONE cycle).
  int          sl [2] = '{3, 5};
  int          pos [2];
  logic [7:0]  m_out [2];
  bit          m_busy [2];
  bit          m_done [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pos[i] = -1; m_out[i] = '0; m_busy[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_edge(input int id, input bit en, input int idx, input bit start);
    if (pos[id] == -1) begin
      m_done[id] = 0;
      if (start) begin
        pos[id] = 0; m_out[id] = 8'd1; m_busy[id] = 1;
      end else begin
        m_busy[id] = 0;
        if (en) m_out[id] = 8'(1 << idx);
        else begin
`ifndef DECODER_HOLD_EN
          m_out[id] = '0;
`endif
        end
      end
    end else if (pos[id] < sl[id]) begin
      pos[id]++;
      m_out[id] = 8'(1 << pos[id]); m_busy[id] = 1; m_done[id] = 0;
    end else if (pos[id] == sl[id]) begin
      pos[id]++;
      m_out[id] = '0; m_busy[id] = 0; m_done[id] = 1;
    end else begin
      pos[id] = -1;
      m_out[id] = '0; m_busy[id] = 0; m_done[id] = 0;
    end
  endtask

  task automatic compare_all();
    logic [7:0] o0;
    o0 = m_out[0];
    check_eq("out0", 32'(bus0.OUT), 32'(o0[3:0]));
    check_eq("busy0", 32'(bus0.BUSY), 32'(m_busy[0]));
    check_eq("done0", 32'(bus0.DONE), 32'(m_done[0]));
    check_eq("out1", 32'(bus1.OUT), 32'(m_out[1]));
    check_eq("busy1", 32'(bus1.BUSY), 32'(m_busy[1]));
    check_eq("done1", 32'(bus1.DONE), 32'(m_done[1]));
    check_eq("onehot0_0", 32'($onehot0(bus0.OUT)), 32'd1);
    check_eq("onehot0_1", 32'($onehot0(bus1.OUT)), 32'd1);
    check_eq("busy_and_done", 32'((bus0.BUSY & bus0.DONE) | (bus1.BUSY & bus1.DONE)), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      model_edge(0, bus0.EN, int'(bus0.IN), bus0.SWEEP_START);
      model_edge(1, bus1.EN, int'(bus1.IN), bus1.SWEEP_START);
    end
    @(negedge clk);
    compare_all();
  endtask

  // Called just after a negedge: reset lands between edges.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_out0", 32'(bus0.OUT), 32'd0);
    check_eq("rst_busy0", 32'(bus0.BUSY), 32'd0);
    check_eq("rst_done0", 32'(bus0.DONE), 32'd0);
    check_eq("rst_out1", 32'(bus1.OUT), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus0.EN = 0; bus0.IN = '0; bus0.SWEEP_START = 0;
    bus1.EN = 0; bus1.IN = '0; bus1.SWEEP_START = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // plain decode of every index, then EN=0 with X on IN
    for (int i = 0; i < 4; i++) begin
      bus0.EN = 1; bus0.IN = 2'(i);
      step();
    end
    bus0.EN = 0; bus0.IN = 'x;
    step();

    // full sweep on dut0, then decode again
    bus0.IN = '0; bus0.SWEEP_START = 1;
    step();
    bus0.SWEEP_START = 0;
    for (int i = 0; i < 6; i++) step();
    bus0.EN = 1; bus0.IN = 2'd2;
    step();

    // sweep request beats EN; inputs toggled mid-sweep
    bus0.EN = 1; bus0.IN = 2'd3; bus0.SWEEP_START = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      bus0.EN = 1'($urandom); bus0.IN = 2'($urandom); bus0.SWEEP_START = 1'($urandom);
      step();
    end
    idle_inputs();
    step();

    // partial sweep on dut1 (SWEEP_LAST=5)
    bus1.SWEEP_START = 1;
    step();
    bus1.SWEEP_START = 0;
    for (int i = 0; i < 8; i++) step();

    // asynchronous reset during the third sweep cycle
    bus0.SWEEP_START = 1;
    step();
    bus0.SWEEP_START = 0;
    step();
    step();
    check_eq("third_sweep_cycle", 32'(bus0.OUT), 32'h4);
    async_reset();
    bus0.EN = 1; bus0.IN = 2'd1;
    step();
    bus0.EN = 0;
    for (int i = 0; i < 4; i++) step();

    // EN=0 after a decode, then a sweep and its aftermath
    bus0.EN = 1; bus0.IN = 2'd2;
    step();
    bus0.EN = 0;
    for (int i = 0; i < 3; i++) step();
    bus0.SWEEP_START = 1;
    step();
    bus0.SWEEP_START = 0;
    for (int i = 0; i < 8; i++) step();

    // randomized traffic on both decoders with occasional mid-cycle reset
    for (int c = 0; c < 400; c++) begin
      bus0.EN = 1'($urandom); bus0.IN = 2'($urandom);
      if (!bus0.EN && $urandom_range(0, 1) == 1) bus0.IN = 'x;
      bus0.SWEEP_START = ($urandom_range(0, 9) == 0);
      bus1.EN = 1'($urandom); bus1.IN = 3'($urandom);
      if (!bus1.EN && $urandom_range(0, 1) == 1) bus1.IN = 'x;
      bus1.SWEEP_START = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) async_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
